// File: rtl/onehot_encoder_pipe_pkg.sv
// Shared types for the registered one-hot / priority encoder.
// Mode encodings and the encoder result bundle.
package onehot_encoder_pipe_pkg;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_PRIO   = 1'b1;

  // Widest code any instance may produce; tops slice to their own W.
  localparam int CODE_MAXW = 32;

  typedef struct packed {
    logic [CODE_MAXW-1:0] code;
    logic                 err;
  } enc_res_t;

endpackage

// File: rtl/onehot_encoder_pipe_core.sv
// Combinational (data, mode) -> (code, err) encoder.
// Strict mode rejects non-one-hot; priority picks the lowest set bit.
module onehot_encode_core
  import onehot_encoder_pipe_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         mode,
  output enc_res_t     res
);

  logic                 found;
  logic                 multi;
  logic [CODE_MAXW-1:0] lo;

  // Scan high to low so the final hit is the lowest set bit.
  always_comb begin
    found = 1'b0;
    multi = 1'b0;
    lo    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (data[i]) begin
        multi = multi | found;
        found = 1'b1;
        lo    = CODE_MAXW'(i);
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (mode)
      MODE_STRICT: begin
        if (found && !multi) res.code = lo;
        else                 res.err  = 1'b1;
      end
      MODE_PRIO: begin
        if (found) res.code = lo;
        else       res.err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered N-to-log2(N) encoder with valid/ready on both sides.
// ONEHOT_ENC_ERRCNT_EN adds a saturating error counter port err_cnt.
module onehot_encoder_pipe
  import onehot_encoder_pipe_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 8,
  localparam int W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_err
`ifdef ONEHOT_ENC_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  enc_res_t res;
  logic     acc;

  onehot_encode_core #(
    .N(N)
  ) u_core (
    .data(in_data),
    .mode(in_mode),
    .res (res)
  );

  // Index is always < N, so bits above W are zero.
  logic [CODE_MAXW-W-1:0] unused_hi;
  assign unused_hi = res.code[CODE_MAXW-1:W];

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_err   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_code  <= res.code[W-1:0];
      out_err   <= res.err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ONEHOT_ENC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (acc && res.err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench for onehot_encoder_pipe (N = 8, 16, 5).
// Counter checks are active when ONEHOT_ENC_ERRCNT_EN is defined.
module tb_onehot_encoder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int exp_cnt = 0;

  logic       iv, ir, im, ov, ordy, oe;
  logic [7:0] id;
  logic [2:0] oc;
  logic [7:0] ec;

  logic        iv16, ir16, im16, ov16, or16, oe16;
  logic [15:0] id16;
  logic [3:0]  oc16;
  logic [7:0]  ec16;

  logic       iv5, ir5, im5, ov5, or5, oe5;
  logic [4:0] id5;
  logic [2:0] oc5;
  logic [7:0] ec5;

  logic       ivs, irs, ims, ovs, ors, oes;
  logic [7:0] ids;
  logic [2:0] ocs;
  logic [1:0] ecs;

  onehot_encoder_pipe #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .in_data(id), .in_mode(im),
    .out_valid(ov), .out_ready(ordy),
    .out_code(oc), .out_err(oe)
`ifdef ONEHOT_ENC_ERRCNT_EN
    , .err_cnt(ec)
`endif
  );

  onehot_encoder_pipe #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .in_data(id16), .in_mode(im16),
    .out_valid(ov16), .out_ready(or16),
    .out_code(oc16), .out_err(oe16)
`ifdef ONEHOT_ENC_ERRCNT_EN
    , .err_cnt(ec16)
`endif
  );

  onehot_encoder_pipe #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv5), .in_ready(ir5),
    .in_data(id5), .in_mode(im5),
    .out_valid(ov5), .out_ready(or5),
    .out_code(oc5), .out_err(oe5)
`ifdef ONEHOT_ENC_ERRCNT_EN
    , .err_cnt(ec5)
`endif
  );

  onehot_encoder_pipe #(.N(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ivs), .in_ready(irs),
    .in_data(ids), .in_mode(ims),
    .out_valid(ovs), .out_ready(ors),
    .out_code(ocs), .out_err(oes)
`ifdef ONEHOT_ENC_ERRCNT_EN
    , .err_cnt(ecs)
`endif
  );

  // Reference: strict needs popcount 1; result is log2 of lowest set bit.
  function automatic void ref_enc(input int unsigned d, input logic m,
                                  output int code, output logic err);
    int unsigned low;
    low = d & (~d + 1);
    if (d == 0 || (m == 1'b0 && $countones(d) != 1)) begin
      code = 0;
      err = 1'b1;
    end else begin
      code = $clog2(low);
      err = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 0; id = 0; im = 0; ordy = 1;
    iv16 = 0; id16 = 0; im16 = 0; or16 = 1;
    iv5 = 0; id5 = 0; im5 = 0; or5 = 1;
    ivs = 0; ids = 0; ims = 0; ors = 1;
    repeat (2) tick();
    compared++; if (ov !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b want 0", ov); end
    compared++; if (oc !== 3'd0) begin mismatched++; $display("FAIL rst_code: got %0d want 0", oc); end
    compared++; if (oe !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", oe); end
`ifdef ONEHOT_ENC_ERRCNT_EN
    compared++; if (ec !== 8'd0) begin mismatched++; $display("FAIL rst_cnt: got %0d want 0", ec); end
`endif
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_pipeline();
    iv = 1; im = 0; id = 8'b0010_0000; ordy = 1;
    #1;
    compared++; if (ir !== 1'b1) begin mismatched++; $display("FAIL pipe_ready0: got %b want 1", ir); end
    tick();
    compared++; if (ov !== 1'b1) begin mismatched++; $display("FAIL pipe_valid: got %b want 1", ov); end
    compared++; if (oc !== 3'd5) begin mismatched++; $display("FAIL pipe_code: got %0d want 5", oc); end
    compared++; if (oe !== 1'b0) begin mismatched++; $display("FAIL pipe_err: got %b want 0", oe); end
    compared++; if (ir !== 1'b1) begin mismatched++; $display("FAIL pipe_ready1: got %b want 1", ir); end
  endtask

  task automatic test_strict_illegal();
    logic [7:0] pats [2];
    pats[0] = 8'b0000_0110;
    pats[1] = 8'b0000_0000;
    iv = 1; im = 0; ordy = 1;
    for (int k = 0; k < 2; k++) begin
      id = pats[k];
      tick();
      exp_cnt++;
      compared++; if (ov !== 1'b1) begin mismatched++; $display("FAIL strict_valid[%0d]: got %b want 1", k, ov); end
      compared++; if (oc !== 3'd0) begin mismatched++; $display("FAIL strict_code[%0d]: got %0d want 0", k, oc); end
      compared++; if (oe !== 1'b1) begin mismatched++; $display("FAIL strict_err[%0d]: got %b want 1", k, oe); end
      compared++; if (ir !== 1'b1) begin mismatched++; $display("FAIL strict_ready[%0d]: got %b want 1", k, ir); end
    end
`ifdef ONEHOT_ENC_ERRCNT_EN
    compared++; if (ec !== 8'(exp_cnt)) begin mismatched++; $display("FAIL strict_cnt: got %0d want %0d", ec, exp_cnt); end
`endif
  endtask

  task automatic test_priority();
    iv = 1; im = 1; ordy = 1;
    id = 8'b1010_1000;
    tick();
    compared++; if (oc !== 3'd3) begin mismatched++; $display("FAIL prio_code: got %0d want 3", oc); end
    compared++; if (oe !== 1'b0) begin mismatched++; $display("FAIL prio_err: got %b want 0", oe); end
    id = 8'b0;
    tick();
    exp_cnt++;
    compared++; if (oc !== 3'd0) begin mismatched++; $display("FAIL prio_zero_code: got %0d want 0", oc); end
    compared++; if (oe !== 1'b1) begin mismatched++; $display("FAIL prio_zero_err: got %b want 1", oe); end
    iv = 0;
    tick();
    compared++; if (ov !== 1'b0) begin mismatched++; $display("FAIL prio_drain: got %b want 0", ov); end
  endtask

  task automatic test_backpressure();
    iv = 1; im = 0; id = 8'b0000_0100; ordy = 1;
    tick();
    id = 8'b1000_0000; ordy = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      compared++; if (ir !== 1'b0) begin mismatched++; $display("FAIL bp_ready[%0d]: got %b want 0", k, ir); end
      tick();
      compared++; if (ov !== 1'b1) begin mismatched++; $display("FAIL bp_valid[%0d]: got %b want 1", k, ov); end
      compared++; if (oc !== 3'd2) begin mismatched++; $display("FAIL bp_code[%0d]: got %0d want 2", k, oc); end
      compared++; if (oe !== 1'b0) begin mismatched++; $display("FAIL bp_err[%0d]: got %b want 0", k, oe); end
    end
    ordy = 1;
    #1;
    compared++; if (ir !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", ir); end
    tick();
    iv = 0;
    compared++; if (ov !== 1'b1) begin mismatched++; $display("FAIL bp_next_valid: got %b want 1", ov); end
    compared++; if (oc !== 3'd7) begin mismatched++; $display("FAIL bp_next_code: got %0d want 7", oc); end
    tick();
    compared++; if (ov !== 1'b0) begin mismatched++; $display("FAIL bp_drain_valid: got %b want 0", ov); end
    compared++; if (oc !== 3'd7) begin mismatched++; $display("FAIL bp_drain_hold: got %0d want 7", oc); end
  endtask

  task automatic test_random();
    bit   ev;
    int   ecode, c;
    logic eerr, e, rdy;
    int   kind;
    rst_n = 0; iv = 0; ordy = 1;
    tick();
    rst_n = 1;
    ev = 0; ecode = 0; eerr = 0; exp_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom % 4) != 0;
      im = 1'($urandom);
      ordy = ($urandom % 4) != 0;
      kind = $urandom % 3;
      if (kind == 0)      id = 8'(1 << ($urandom % 8));
      else if (kind == 1) id = 8'($urandom);
      else                id = 8'($urandom % 2);
      rdy = !ev || ordy;
      #1;
      compared++; if (ir !== rdy) begin mismatched++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ir, rdy); end
      if (iv && rdy) begin
        ref_enc(32'(id), im, c, e);
        ev = 1; ecode = c; eerr = e;
        if (e && exp_cnt < 255) exp_cnt++;
      end else if (ev && ordy) begin
        ev = 0;
      end
      tick();
      compared++; if (ov !== ev) begin mismatched++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ov, ev); end
      compared++; if (oc !== 3'(ecode)) begin mismatched++; $display("FAIL rnd_code[%0d]: got %0d want %0d", n, oc, ecode); end
      compared++; if (oe !== eerr) begin mismatched++; $display("FAIL rnd_err[%0d]: got %b want %b", n, oe, eerr); end
`ifdef ONEHOT_ENC_ERRCNT_EN
      compared++; if (ec !== 8'(exp_cnt)) begin mismatched++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, ec, exp_cnt); end
`endif
    end
    iv = 0; ordy = 1;
    tick();
  endtask

  task automatic test_sweep16();
    iv16 = 1; im16 = 0; or16 = 1;
    for (int i = 0; i < 16; i++) begin
      id16 = 16'(1 << i);
      tick();
      compared++; if (oc16 !== 4'(i)) begin mismatched++; $display("FAIL n16_code[%0d]: got %0d want %0d", i, oc16, i); end
      compared++; if (oe16 !== 1'b0) begin mismatched++; $display("FAIL n16_err[%0d]: got %b want 0", i, oe16); end
    end
    iv16 = 0;
    tick();
  endtask

  task automatic test_n5();
    iv5 = 1; im5 = 0; or5 = 1;
    id5 = 5'b10000;
    tick();
    compared++; if (oc5 !== 3'd4) begin mismatched++; $display("FAIL n5_code: got %0d want 4", oc5); end
    compared++; if (oe5 !== 1'b0) begin mismatched++; $display("FAIL n5_err: got %b want 0", oe5); end
    id5 = 5'b00011;
    tick();
    compared++; if (oe5 !== 1'b1) begin mismatched++; $display("FAIL n5_multi_err: got %b want 1", oe5); end
    compared++; if (oc5 !== 3'd0) begin mismatched++; $display("FAIL n5_multi_code: got %0d want 0", oc5); end
    im5 = 1;
    tick();
    compared++; if (oe5 !== 1'b0) begin mismatched++; $display("FAIL n5_prio_err: got %b want 0", oe5); end
    compared++; if (oc5 !== 3'd0) begin mismatched++; $display("FAIL n5_prio_code: got %0d want 0", oc5); end
    iv5 = 0;
    tick();
  endtask

  task automatic test_saturate();
    ivs = 1; ims = 0; ids = 8'b0; ors = 1;
    repeat (5) tick();
    ivs = 0;
    compared++; if (oes !== 1'b1) begin mismatched++; $display("FAIL sat_err: got %b want 1", oes); end
`ifdef ONEHOT_ENC_ERRCNT_EN
    compared++; if (ecs !== 2'd3) begin mismatched++; $display("FAIL sat_cnt: got %0d want 3", ecs); end
`endif
    tick();
  endtask

  task automatic test_midreset();
    iv = 1; im = 0; id = 8'b0000_0110; ordy = 0;
    tick();
    iv = 0;
    compared++; if (ov !== 1'b1) begin mismatched++; $display("FAIL mid_pre_valid: got %b want 1", ov); end
    rst_n = 0;
    tick();
    compared++; if (ov !== 1'b0) begin mismatched++; $display("FAIL mid_valid: got %b want 0", ov); end
    compared++; if (oc !== 3'd0) begin mismatched++; $display("FAIL mid_code: got %0d want 0", oc); end
    compared++; if (oe !== 1'b0) begin mismatched++; $display("FAIL mid_err: got %b want 0", oe); end
`ifdef ONEHOT_ENC_ERRCNT_EN
    compared++; if (ec !== 8'd0) begin mismatched++; $display("FAIL mid_cnt: got %0d want 0", ec); end
`endif
    rst_n = 1; ordy = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_strict_illegal();
    test_priority();
    test_backpressure();
    test_random();
    test_sweep16();
    test_n5();
    test_saturate();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Parametrised, registered N-to-log2(N) encoder with valid/ready handshake on input and output.
- Two run-time modes: strict one-hot, which flags invalid codes, and LSB-first priority.
- Replaces the fixed 8-bit combinational one-hot encoder in datapaths that need backpressure and error reporting.
- Sits between request/arbiter logic and downstream index consumers.

Parameters:
- N, 8, input vector width; integer >= 2.
- W, $clog2(N), output code width; localparam derived from N, not overridable.
- CNT_W, 8, error counter width; used only when the optional feature is enabled.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_data and in_mode are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  N  vector to encode.
- in_mode  input  1  0 = strict one-hot, 1 = LSB-first priority.
- out_valid  output  1  out_code and out_err hold a result.
- out_ready  input  1  downstream accepts the result.
- out_code  output  W  encoded index.
- out_err  output  1  input was illegal for its mode.
- err_cnt  output  CNT_W  saturating error count; present only with ONEHOT_ENC_ERRCNT_EN.

Behaviour:
- Reset: one clock, one active-low reset; the reset is synchronous and active-low. While rst_n = 0 at a rising edge: out_valid = 0, out_code = 0, out_err = 0, err_cnt = 0.
- Reset mid-operation: any held result is dropped with no output handshake.
- Storage: single-entry output register.
  - in_ready = !out_valid || out_ready (combinational; pass-through when downstream is ready).
  - Accept occurs when in_valid && in_ready.
  - Latency: result is visible the cycle after accept; sustained throughput is 1 per cycle when out_ready = 1.
- Output register update on each rising edge:
  - Accept: load the new result; out_valid = 1.
  - No accept, and out_valid && out_ready: out_valid = 0; out_code and out_err keep their values.
  - Otherwise: hold.
- Stability: while out_valid && !out_ready, out_code and out_err must not change.
- Mode sampling: in_mode is sampled with in_data at accept. A mode change only affects later accepts.
- Strict mode (in_mode = 0):
  - Exactly one bit set: out_code = its index, out_err = 0.
  - Zero bits or two or more bits set: out_code = 0, out_err = 1.
- Priority mode (in_mode = 1):
  - Any bit set: out_code = index of the lowest set bit, out_err = 0.
  - All zero: out_code = 0, out_err = 1.
- Width: out_code is zero-extended index; the index is always < N, and no X is ever driven.
- in_data and in_mode are ignored when in_valid = 0.

Optional Feature:
- Macro: ONEHOT_ENC_ERRCNT_EN.
- Defined:
  - err_cnt port exists.
  - It increments by 1 on each accept whose computed result has err = 1.
  - It saturates at 2^CNT_W - 1.
  - Reset clears it to 0.
- Not defined: the err_cnt port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: mode constants MODE_STRICT = 1'b0 and MODE_PRIO = 1'b1, plus a result struct {code[W], err}.
- One sub-module, onehot_encode_core: purely combinational (data, mode) -> (code, err), so it can be unit-tested exhaustively.
- The top level holds the handshake register and the counter.

Test Plan:
- Reset and pipelining: reset, then N = 8, strict, in_data = 8'b0010_0000, out_ready = 1 -> next cycle out_valid = 1, out_code = 5, out_err = 0; in_ready stays 1 on every cycle.
- Strict illegal inputs: in_data = 8'b0000_0110 and then 8'b0 -> out_code = 0, out_err = 1 both times. With ONEHOT_ENC_ERRCNT_EN defined, err_cnt = 2.
- Priority mode: in_data = 8'b1010_1000 -> out_code = 3, out_err = 0; in_data = 8'b0 -> out_code = 0, out_err = 1.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> in_ready = 0, and out_code/out_err remain stable. Raise out_ready together with a new in_valid -> old result handshakes and the new result appears next cycle with no gap.
- Parameter and saturation sweep:
  - N = 16: exhaustive strict one-hot walk, bit i -> out_code = i.
  - N = 5: in_data = 5'b10000 -> out_code = 4.
  - CNT_W = 2: 5 errors -> err_cnt = 3.
- Reset mid-flight: rst_n = 0 while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, out_code = 0, err_cnt = 0.
